// File: rtl/dmem_load_unit_if.sv
// Request/response bundle between the MEM stage and the data-memory load unit.
interface dmem_load_unit_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        load_sel_M;
    logic [ADDR_W-1:0] addr;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_misalign;
    logic              err;

    modport master (
        output req_valid, load_sel_M, addr,
        input  req_ready, resp_valid, resp_data, resp_misalign, err
    );

    modport slave (
        input  req_valid, load_sel_M, addr,
        output req_ready, resp_valid, resp_data, resp_misalign, err
    );
endinterface

// File: rtl/dmem_load_unit.sv
// Load unit for the word-wide data memory: issues one or two synchronous word
// reads per load, merges word-crossing accesses and returns an extended result.
module dmem_load_unit #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_load_unit_if.slave     bus,
    output logic                mem_re,
    output logic [ADDR_W-3:0]   mem_RA,
    input  logic [31:0]         mem_RD
);
    localparam int unsigned IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      w0_q, w0_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_misalign_q, resp_misalign_d;
    logic             err_q, err_d;

    logic             sel_legal;
    logic             split;
    logic [IDX_W-1:0] idx_next;

    // Shift the merged double word to the load's byte offset, then extend.
    function automatic logic [31:0] form_result(input logic [2:0]  sel,
                                                input logic [1:0]  off,
                                                input logic [63:0] dw);
        logic [63:0] sh;
        sh = dw >> {off, 3'b000};
        case (sel)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return sh[31:0];
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Illegal selects never split, so err and misalign are mutually exclusive.
    always_comb begin
        sel_legal = (sel_q == 3'b000) || (sel_q == 3'b001) || (sel_q == 3'b010) ||
                    (sel_q == 3'b100) || (sel_q == 3'b101);
        split     = sel_legal &&
                    (((sel_q[1:0] == 2'b01) && (off_q == 2'd3)) ||
                     ((sel_q[1:0] == 2'b10) && (off_q != 2'd0)));
        idx_next  = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            sel_q           <= '0;
            off_q           <= '0;
            w0_q            <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_misalign_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            sel_q           <= sel_d;
            off_q           <= off_d;
            w0_q            <= w0_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_misalign_q <= resp_misalign_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = RD0;
            RD0:     state_d = split ? RD1 : RESP;
            RD1:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port drive and datapath register updates.
    always_comb begin
        bus.req_ready   = 1'b0;
        mem_re          = 1'b0;
        mem_RA          = idx_q;
        idx_d           = idx_q;
        sel_d           = sel_q;
        off_d           = off_q;
        w0_d            = w0_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        resp_misalign_d = 1'b0;
        err_d           = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    mem_re = 1'b1;
                    mem_RA = bus.addr[ADDR_W-1:2];
                    idx_d  = bus.addr[ADDR_W-1:2];
                    sel_d  = bus.load_sel_M;
                    off_d  = bus.addr[1:0];
                end
            end
            RD0: begin
                w0_d = mem_RD;
                if (split) begin
                    mem_re = 1'b1;
                    mem_RA = idx_next;
                end else begin
                    resp_data_d  = form_result(sel_q, off_q, {32'h0, mem_RD});
                    resp_valid_d = 1'b1;
                    err_d        = !sel_legal;
                end
            end
            RD1: begin
                resp_data_d     = form_result(sel_q, off_q, {mem_RD, w0_q});
                resp_valid_d    = 1'b1;
                resp_misalign_d = 1'b1;
                err_d           = !sel_legal;
            end
            default: ;
        endcase
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.err           = err_q;
endmodule
